// File: rtl/quad_step_decoder.sv
// Quadrature detent decoder: synchronizes PmodENC A/B/BTN, tracks full detent cycles and keeps a bounded count.
// Optional build macro QUAD_SATURATE_EN makes the count saturate at 0 / CNT_MAX instead of wrapping.
`timescale 1ns/1ps

module quad_step_decoder #(
    parameter int CNT_W   = 5,
    parameter int CNT_MAX = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             btn_in,
    output logic [CNT_W-1:0] count,
    output logic             dir,
    output logic             step,
    output logic             btn_pulse,
    output logic             err
);

    typedef enum logic [2:0] {
        ST_REST = 3'd0,
        ST_CW1  = 3'd1,
        ST_CW2  = 3'd2,
        ST_CW3  = 3'd3,
        ST_CCW1 = 3'd4,
        ST_CCW2 = 3'd5,
        ST_CCW3 = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX_V = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             a_meta_r;
    logic             a_sync_r;
    logic             b_meta_r;
    logic             b_sync_r;
    logic             btn_meta_r;
    logic             btn_sync_r;
    logic [1:0]       ab_prev_r;
    logic             btn_prev_r;

    state_t           state_r;
    state_t           state_s;
    logic             commit_cw_s;
    logic             commit_ccw_s;

    logic [1:0]       ab_s;
    logic             illegal_s;
    logic             btn_rise_s;

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_s;
    logic             dir_r;
    logic             dir_s;
    logic             step_r;
    logic             step_s;
    logic             btn_pulse_r;
    logic             btn_pulse_s;
    logic             err_r;
    logic             err_s;

    assign ab_s       = {a_sync_r, b_sync_r};
    assign illegal_s  = ((ab_s ^ ab_prev_r) == 2'b11);
    assign btn_rise_s = btn_sync_r & ~btn_prev_r;

    // Two-flop synchronizers plus one-sample history for edge/jump detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_meta_r   <= 1'b1;
            a_sync_r   <= 1'b1;
            b_meta_r   <= 1'b1;
            b_sync_r   <= 1'b1;
            btn_meta_r <= 1'b0;
            btn_sync_r <= 1'b0;
            ab_prev_r  <= 2'b11;
            btn_prev_r <= 1'b0;
        end else begin
            a_meta_r   <= a_in;
            a_sync_r   <= a_meta_r;
            b_meta_r   <= b_in;
            b_sync_r   <= b_meta_r;
            btn_meta_r <= btn_in;
            btn_sync_r <= btn_meta_r;
            ab_prev_r  <= ab_s;
            btn_prev_r <= btn_sync_r;
        end
    end

    // Phase-tracking state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_REST;
        end else begin
            state_r <= state_s;
        end
    end

    // Next phase: one-phase forward or back moves only; a double jump holds unless it lands on rest.
    always_comb begin
        state_s      = state_r;
        commit_cw_s  = 1'b0;
        commit_ccw_s = 1'b0;
        if (illegal_s) begin
            if (ab_s == 2'b11) begin
                state_s = ST_REST;
            end else begin
                state_s = state_r;
            end
        end else begin
            case (state_r)
                ST_REST: begin
                    if (ab_s == 2'b01) begin
                        state_s = ST_CW1;
                    end else if (ab_s == 2'b10) begin
                        state_s = ST_CCW1;
                    end else begin
                        state_s = ST_REST;
                    end
                end
                ST_CW1: begin
                    if (ab_s == 2'b00) begin
                        state_s = ST_CW2;
                    end else if (ab_s == 2'b11) begin
                        state_s = ST_REST;
                    end else begin
                        state_s = ST_CW1;
                    end
                end
                ST_CW2: begin
                    if (ab_s == 2'b10) begin
                        state_s = ST_CW3;
                    end else if (ab_s == 2'b01) begin
                        state_s = ST_CW1;
                    end else begin
                        state_s = ST_CW2;
                    end
                end
                ST_CW3: begin
                    if (ab_s == 2'b11) begin
                        state_s     = ST_REST;
                        commit_cw_s = 1'b1;
                    end else if (ab_s == 2'b00) begin
                        state_s = ST_CW2;
                    end else begin
                        state_s = ST_CW3;
                    end
                end
                ST_CCW1: begin
                    if (ab_s == 2'b00) begin
                        state_s = ST_CCW2;
                    end else if (ab_s == 2'b11) begin
                        state_s = ST_REST;
                    end else begin
                        state_s = ST_CCW1;
                    end
                end
                ST_CCW2: begin
                    if (ab_s == 2'b01) begin
                        state_s = ST_CCW3;
                    end else if (ab_s == 2'b10) begin
                        state_s = ST_CCW1;
                    end else begin
                        state_s = ST_CCW2;
                    end
                end
                ST_CCW3: begin
                    if (ab_s == 2'b11) begin
                        state_s      = ST_REST;
                        commit_ccw_s = 1'b1;
                    end else if (ab_s == 2'b00) begin
                        state_s = ST_CCW2;
                    end else begin
                        state_s = ST_CCW3;
                    end
                end
                default: begin
                    state_s = ST_REST;
                end
            endcase
        end
    end

    // Output datapath: a button edge clears and overrides any commit in the same cycle.
    always_comb begin
        count_s     = count_r;
        dir_s       = dir_r;
        step_s      = 1'b0;
        btn_pulse_s = 1'b0;
        err_s       = err_r | illegal_s;
        if (btn_rise_s) begin
            count_s     = CNT_ZERO;
            btn_pulse_s = 1'b1;
            err_s       = 1'b0;
        end else if (commit_cw_s) begin
            dir_s = 1'b1;
`ifdef QUAD_SATURATE_EN
            if (count_r == CNT_MAX_V) begin
                count_s = count_r;
                step_s  = 1'b0;
            end else begin
                count_s = count_r + CNT_ONE;
                step_s  = 1'b1;
            end
`else
            if (count_r == CNT_MAX_V) begin
                count_s = CNT_ZERO;
            end else begin
                count_s = count_r + CNT_ONE;
            end
            step_s = 1'b1;
`endif
        end else if (commit_ccw_s) begin
            dir_s = 1'b0;
`ifdef QUAD_SATURATE_EN
            if (count_r == CNT_ZERO) begin
                count_s = count_r;
                step_s  = 1'b0;
            end else begin
                count_s = count_r - CNT_ONE;
                step_s  = 1'b1;
            end
`else
            if (count_r == CNT_ZERO) begin
                count_s = CNT_MAX_V;
            end else begin
                count_s = count_r - CNT_ONE;
            end
            step_s = 1'b1;
`endif
        end else begin
            count_s = count_r;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r     <= CNT_ZERO;
            dir_r       <= 1'b1;
            step_r      <= 1'b0;
            btn_pulse_r <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            count_r     <= count_s;
            dir_r       <= dir_s;
            step_r      <= step_s;
            btn_pulse_r <= btn_pulse_s;
            err_r       <= err_s;
        end
    end

    assign count     = count_r;
    assign dir       = dir_r;
    assign step      = step_r;
    assign btn_pulse = btn_pulse_r;
    assign err       = err_r;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Self-checking bench for quad_step_decoder: scoreboard of expected step/button events plus per-scenario checks.
`timescale 1ns/1ps

module tb_quad_step_decoder;

    typedef struct packed {
        logic       is_btn;
        logic [4:0] cnt;
        logic       dir;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic       a_in;
    logic       b_in;
    logic       btn_in;
    logic [4:0] count;
    logic       dir;
    logic       step;
    logic       btn_pulse;
    logic       err;

    int         checks;
    int         errors;
    ev_t        sb_q[$];
    ev_t        mon_ev;
    logic       prev_step;
    logic       prev_btn;

    logic [4:0] exp_count;
    logic       exp_dir;
    logic       exp_err;

    quad_step_decoder #(.CNT_W(5), .CNT_MAX(19)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_in      (a_in),
        .b_in      (b_in),
        .btn_in    (btn_in),
        .count     (count),
        .dir       (dir),
        .step      (step),
        .btn_pulse (btn_pulse),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor: every step/btn_pulse must match the oldest expected event.
    initial begin
        prev_step = 1'b0;
        prev_btn  = 1'b0;
        forever begin
            @(negedge clk);
            if (step === 1'b1 || btn_pulse === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: step=%0b btn_pulse=%0b count=%0d dir=%0b, none expected",
                             step, btn_pulse, count, dir);
                end else begin
                    mon_ev = sb_q.pop_front();
                    if ({step, btn_pulse, count, dir} !== {~mon_ev.is_btn, mon_ev.is_btn, mon_ev.cnt, mon_ev.dir}) begin
                        errors++;
                        $display("FAIL event: got step=%0b btn=%0b count=%0d dir=%0b, expected step=%0b btn=%0b count=%0d dir=%0b",
                                 step, btn_pulse, count, dir, ~mon_ev.is_btn, mon_ev.is_btn, mon_ev.cnt, mon_ev.dir);
                    end
                end
            end
            if (step === 1'b1 && prev_step === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL step_width: step high 2 consecutive cycles, expected 1");
            end
            if (btn_pulse === 1'b1 && prev_btn === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL btn_width: btn_pulse high 2 consecutive cycles, expected 1");
            end
            prev_step = step;
            prev_btn  = btn_pulse;
        end
    end

    task automatic push_ev(input logic is_btn, input logic [4:0] c, input logic d);
        ev_t e;
        e.is_btn = is_btn;
        e.cnt    = c;
        e.dir    = d;
        sb_q.push_back(e);
    endtask

    task automatic expect_cw();
        exp_dir = 1'b1;
`ifdef QUAD_SATURATE_EN
        if (exp_count != 5'd19) begin
            exp_count = exp_count + 5'd1;
            push_ev(1'b0, exp_count, exp_dir);
        end
`else
        exp_count = (exp_count == 5'd19) ? 5'd0 : exp_count + 5'd1;
        push_ev(1'b0, exp_count, exp_dir);
`endif
    endtask

    task automatic expect_ccw();
        exp_dir = 1'b0;
`ifdef QUAD_SATURATE_EN
        if (exp_count != 5'd0) begin
            exp_count = exp_count - 5'd1;
            push_ev(1'b0, exp_count, exp_dir);
        end
`else
        exp_count = (exp_count == 5'd0) ? 5'd19 : exp_count - 5'd1;
        push_ev(1'b0, exp_count, exp_dir);
`endif
    endtask

    task automatic drive_ab(input logic a, input logic b, input int n);
        a_in = a;
        b_in = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic cw_cycle(input int n);
        drive_ab(1'b0, 1'b1, n);
        drive_ab(1'b0, 1'b0, n);
        drive_ab(1'b1, 1'b0, n);
        expect_cw();
        drive_ab(1'b1, 1'b1, n);
    endtask

    task automatic check_state(input string name);
        checks++;
        if ({count, dir, err} !== {exp_count, exp_dir, exp_err}) begin
            errors++;
            $display("FAIL %s: got count=%0d dir=%0b err=%0b, expected count=%0d dir=%0b err=%0b",
                     name, count, dir, err, exp_count, exp_dir, exp_err);
        end
    endtask

    task automatic btn_press(input string name);
        int pulses;
        pulses = 0;
        push_ev(1'b1, 5'd0, exp_dir);
        btn_in = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (btn_pulse === 1'b1) pulses++;
        end
        btn_in = 1'b0;
        repeat (4) @(negedge clk);
        exp_count = 5'd0;
        exp_err   = 1'b0;
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL %s_pulses: got %0d btn_pulse cycles, expected 1", name, pulses);
        end
        check_state(name);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        a_in   = 1'b1;
        b_in   = 1'b1;
        btn_in = 1'b0;
        repeat (3) @(negedge clk);
        exp_count = 5'd0;
        exp_dir   = 1'b1;
        exp_err   = 1'b0;
        check_state("reset");
        checks++;
        if ({step, btn_pulse} !== 2'b00) begin
            errors++;
            $display("FAIL reset_pulses: got step=%0b btn_pulse=%0b, expected 0 0", step, btn_pulse);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_cw_detent();
        int hits;
        int pos;
        hits = 0;
        pos  = 0;
        drive_ab(1'b0, 1'b1, 8);
        drive_ab(1'b0, 1'b0, 8);
        drive_ab(1'b1, 1'b0, 8);
        expect_cw();
        a_in = 1'b1;
        b_in = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (step === 1'b1) begin
                hits++;
                pos = k;
            end
        end
        checks++;
        if (hits != 1 || pos != 3) begin
            errors++;
            $display("FAIL cw_latency: got %0d pulses at cycle %0d, expected 1 pulse at cycle 3", hits, pos);
        end
        check_state("cw_detent");
    endtask

    task automatic test_ccw_wrap();
        btn_press("ccw_clear");
        drive_ab(1'b1, 1'b0, 8);
        drive_ab(1'b0, 1'b0, 8);
        drive_ab(1'b0, 1'b1, 8);
        expect_ccw();
        drive_ab(1'b1, 1'b1, 8);
        check_state("ccw_wrap");
    endtask

    task automatic test_backtrack();
        drive_ab(1'b0, 1'b1, 8);
        drive_ab(1'b0, 1'b0, 8);
        drive_ab(1'b0, 1'b1, 8);
        drive_ab(1'b1, 1'b1, 8);
        check_state("backtrack");
    endtask

    task automatic test_illegal();
        drive_ab(1'b0, 1'b0, 8);
        exp_err = 1'b1;
        check_state("illegal_jump");
        btn_press("illegal_clear");
        drive_ab(1'b0, 1'b1, 8);
        drive_ab(1'b1, 1'b1, 8);
        check_state("illegal_recover");
    endtask

    task automatic test_simultaneous();
        int steps;
        int pulses;
        steps  = 0;
        pulses = 0;
        for (int i = 0; i < 5; i++) cw_cycle(4);
        check_state("sim_count5");
        drive_ab(1'b0, 1'b1, 4);
        drive_ab(1'b0, 1'b0, 4);
        drive_ab(1'b1, 1'b0, 4);
        push_ev(1'b1, 5'd0, exp_dir);
        a_in   = 1'b1;
        b_in   = 1'b1;
        btn_in = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (step === 1'b1) steps++;
            if (btn_pulse === 1'b1) pulses++;
        end
        btn_in = 1'b0;
        repeat (4) @(negedge clk);
        exp_count = 5'd0;
        checks++;
        if (steps != 0 || pulses != 1) begin
            errors++;
            $display("FAIL simultaneous_pulses: got step=%0d btn_pulse=%0d cycles, expected 0 and 1", steps, pulses);
        end
        check_state("simultaneous");
    endtask

    task automatic test_reset_mid();
        drive_ab(1'b0, 1'b1, 8);
        drive_ab(1'b0, 1'b0, 8);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        exp_count = 5'd0;
        exp_dir   = 1'b1;
        exp_err   = 1'b0;
        check_state("reset_mid_low");
        rst_n = 1'b1;
        drive_ab(1'b0, 1'b0, 8);
        exp_err = 1'b1;
        check_state("reset_mid_jump");
        drive_ab(1'b1, 1'b0, 8);
        drive_ab(1'b1, 1'b1, 8);
        check_state("reset_mid_end");
    endtask

    task automatic test_back_to_back();
        btn_press("b2b_clear");
        for (int i = 0; i < 21; i++) cw_cycle(2);
        repeat (4) @(negedge clk);
        check_state("b2b_cw_wrap");
        for (int i = 0; i < 3; i++) begin
            drive_ab(1'b1, 1'b0, 2);
            drive_ab(1'b0, 1'b0, 2);
            drive_ab(1'b0, 1'b1, 2);
            expect_ccw();
            drive_ab(1'b1, 1'b1, 2);
        end
        repeat (4) @(negedge clk);
        check_state("b2b_ccw");
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_count = 5'd0;
        exp_dir   = 1'b1;
        exp_err   = 1'b0;
        rst_n     = 1'b0;
        a_in      = 1'b1;
        b_in      = 1'b1;
        btn_in    = 1'b0;
        @(negedge clk);
        test_reset();
        test_cw_detent();
        test_ccw_wrap();
        test_backtrack();
        test_illegal();
        test_simultaneous();
        test_reset_mid();
        test_back_to_back();
        repeat (6) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expected events never seen, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
